gearbox_stream_gen: RTL and testbench
=====================================

Name: gearbox_stream_gen

Overview:
- Parametrised stimulus source for gearbox benches; next generation of the fixed 24-bit, single-frame generator.
- Emits framed, byte-lane-incrementing data with a valid/ready handshake, selectable throttle modes, programmable frame length, inter-frame gap and frame count.
- Sits in 03_sim and drives the DUT input side; a checker regenerates the same sequence from the same parameters.

Parameters:
- DATA_W, 24, data width in bits; must be a multiple of BYTE_W.
- BYTE_W, 8, lane width; each lane increments independently.
- INIT_DATA, 24'h30_20_10, data value after reset (lane0 = LSB lane).
- INC_STEP, 1, per-lane increment applied on each accepted beat.
- START_DLY, 1000, cycles spent in IDLE after reset or gen_en rise before the first beat.
- FRAME_LEN, 9010, beats per frame; legal range is 1 to 2^32-1.
- GAP_LEN, 0, idle cycles between frames; 0 means back-to-back frames.
- NUM_FRAMES, 1, frames to send; 0 means unlimited.
- MODE, 0, throttle mode: 0 = always, 1 = 2-on/2-off from free-running cycle counter bit 1, 2 = LFSR bit 0, 3 = always (reserved).
- SEED, 16'hACE1, LFSR seed; a value of 0 is forced to 1.

Ports:
- clk_200m, in, 1, sole clock.
- reset_n, in, 1, asynchronous active-low reset.
- gen_en, in, 1, generator enable; sampled only in IDLE and at frame boundaries.
- data_rdy, in, 1, downstream ready.
- data_en, out, 1, beat valid.
- data_last, out, 1, last beat of frame; qualified by data_en.
- data_out, out, DATA_W, beat data.
- frame_cnt, out, 32, frames fully accepted since reset.
- done, out, 1, sticky; set when NUM_FRAMES frames are complete.

Behaviour:
- Reset (asynchronous assert, synchronous-safe release): data_en=0, data_last=0, data_out=INIT_DATA, frame_cnt=0, done=0, state=IDLE, cycle counter=0, LFSR=SEED.
- Handshake: a beat transfers on a cycle where data_en && data_rdy.
- While data_en=1 and data_rdy=0: data_out, data_last and data_en hold stable. Throttle never withdraws a pending beat.
- Throttle gates only the issue of a new beat. A new beat may be presented when the state is RUN and the throttle is 1, and either no beat is pending or the current beat transfers this cycle. Registered outputs, so a beat is issued one cycle after the throttle decision.
- LFSR: 16-bit Fibonacci, taps 16/14/13/11, advances every cycle regardless of state.
- Cycle counter: free-running, 32-bit, wraps.
- State machine:
  - IDLE: count START_DLY cycles while gen_en=1; the count clears if gen_en=0. Move to RUN on reaching START_DLY.
  - RUN: issue beats. beat_cnt counts transfers, 0 to FRAME_LEN-1. data_last=1 on the beat where beat_cnt==FRAME_LEN-1. On transfer of the last beat: frame_cnt+1, beat_cnt=0, then evaluate in order:
    - NUM_FRAMES!=0 and frame_cnt+1==NUM_FRAMES: go to DONE.
    - else gen_en=0: go to IDLE.
    - else GAP_LEN>0: go to GAP.
    - else stay in RUN; the next beat may issue on the following cycle.
  - GAP: count GAP_LEN cycles with data_en=0, then go to RUN. If gen_en=0 at gap end, go to IDLE instead.
  - DONE: data_en=0, done=1. Remain here until reset.
- gen_en deassert mid-frame: the current frame completes normally.
- Data arithmetic: on each transfer, every lane becomes (lane + INC_STEP) mod 2^BYTE_W. No carry between lanes. data_out is not reset between frames.
- FRAME_LEN=1: every beat carries data_last=1.
- frame_cnt wraps at 2^32. done does not depend on frame_cnt wrap when NUM_FRAMES=0.

Test Plan:
- Defaults, MODE=0, data_rdy=1: first data_en at cycle 1001 after reset release ±1; data_out=0x302010, 0x313111, …; exactly 9010 beats; data_last on the beat 0x30+9009 mod 256 per lane; then done=1, frame_cnt=1.
- MODE=1, FRAME_LEN=8: beats occur in 2-on/2-off bursts; 8 transfers then data_last; data values contiguous with no skipped increments.
- MODE=0, data_rdy toggled pseudo-randomly: data_out/data_last stable across every data_en&&!data_rdy cycle; checker sees an unbroken +1 per-lane sequence.
- NUM_FRAMES=3, GAP_LEN=5, FRAME_LEN=4: three 4-beat frames separated by exactly 5 idle cycles; frame_cnt steps 1, 2, 3; done rises after the third last beat.
- Lane wrap, INIT_DATA=24'hFF_FE_FD, FRAME_LEN=4: data_out sequence FFFEFD, 00FFFE, 0100FF, 020100.
- reset_n pulsed low mid-frame (asynchronous, between clock edges): outputs return to reset values immediately; restart waits START_DLY; frame_cnt=0.

Source files
------------

// File: rtl/gearbox_stream_gen_if.sv
// Valid/ready beat stream between the stimulus generator (master) and the DUT input side (slave).
interface gearbox_stream_gen_if #(
    parameter int unsigned DATA_W = 24
) ();
    logic              data_en;
    logic              data_last;
    logic [DATA_W-1:0] data_out;
    logic              data_rdy;

    modport master (
        output data_en,
        output data_last,
        output data_out,
        input  data_rdy
    );

    modport slave (
        input  data_en,
        input  data_last,
        input  data_out,
        output data_rdy
    );
endinterface

// File: rtl/gearbox_stream_gen.sv
// Framed, lane-incrementing stream source with throttle modes, frame gap and frame count.
module gearbox_stream_gen #(
    parameter int unsigned       DATA_W     = 24,
    parameter int unsigned       BYTE_W     = 8,
    parameter logic [DATA_W-1:0] INIT_DATA  = 24'h30_20_10,
    parameter int unsigned       INC_STEP   = 1,
    parameter int unsigned       START_DLY  = 1000,
    parameter int unsigned       FRAME_LEN  = 9010,
    parameter int unsigned       GAP_LEN    = 0,
    parameter int unsigned       NUM_FRAMES = 1,
    parameter int unsigned       MODE       = 0,
    parameter logic [15:0]       SEED       = 16'hACE1
) (
    input  logic                 clk_200m,
    input  logic                 reset_n,
    input  logic                 gen_en,
    gearbox_stream_gen_if.master strm,
    output logic [31:0]          frame_cnt,
    output logic                 done
);

    localparam int unsigned       LANES    = DATA_W / BYTE_W;
    localparam logic [15:0]       SEED_EFF = (SEED == 16'h0) ? 16'h0001 : SEED;
    localparam logic [31:0]       LAST_IDX = 32'(FRAME_LEN - 1);
    localparam logic [BYTE_W-1:0] STEP     = BYTE_W'(INC_STEP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_GAP,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       dly_q, dly_d;
    logic [31:0]       gap_q, gap_d;
    logic [31:0]       beat_q, beat_d;
    logic [31:0]       cyc_q, cyc_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic              en_q, en_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [31:0]       frame_q, frame_d;
    logic              done_q, done_d;

    logic throttle;
    logic xfer;
    logic xfer_last;
    logic issue_ok;
    logic issue;

    always_comb begin
        unique case (MODE)
            32'd1:   throttle = cyc_q[1];
            32'd2:   throttle = lfsr_q[0];
            default: throttle = 1'b1;
        endcase
    end

    assign xfer      = en_q && strm.data_rdy;
    assign xfer_last = xfer && last_q;

    always_comb begin
        state_d  = state_q;
        dly_d    = '0;
        gap_d    = '0;
        beat_d   = beat_q;
        frame_d  = frame_q;
        done_d   = done_q;
        data_d   = data_q;
        issue_ok = 1'b0;
        cyc_d    = cyc_q + 32'd1;
        lfsr_d   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

        if (xfer) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                data_d[i*BYTE_W +: BYTE_W] = data_q[i*BYTE_W +: BYTE_W] + STEP;
            end
            beat_d = last_q ? '0 : beat_q + 32'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (gen_en) begin
                    if (dly_q + 32'd1 >= START_DLY) begin
                        state_d = S_RUN;
                    end else begin
                        dly_d = dly_q + 32'd1;
                    end
                end
            end
            S_RUN: begin
                issue_ok = 1'b1;
                if (xfer_last) begin
                    frame_d = frame_q + 32'd1;
                    if ((NUM_FRAMES != 0) && (frame_q + 32'd1 == NUM_FRAMES)) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        issue_ok = 1'b0;
                    end else if (!gen_en) begin
                        state_d  = S_IDLE;
                        issue_ok = 1'b0;
                    end else if (GAP_LEN > 0) begin
                        state_d  = S_GAP;
                        issue_ok = 1'b0;
                    end
                end
            end
            S_GAP: begin
                // The final gap cycle already makes the issue decision, so the
                // registered beat lands right after exactly GAP_LEN idle cycles.
                if (gap_q + 32'd1 >= GAP_LEN) begin
                    if (gen_en) begin
                        state_d  = S_RUN;
                        issue_ok = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_d = gap_q + 32'd1;
                end
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        issue = issue_ok && throttle && (!en_q || xfer);

        if (issue) begin
            en_d   = 1'b1;
            last_d = (beat_d == LAST_IDX);
        end else if (en_q && !xfer) begin
            en_d   = 1'b1;
            last_d = last_q;
        end else begin
            en_d   = 1'b0;
            last_d = 1'b0;
        end
    end

    always_ff @(posedge clk_200m or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            dly_q   <= '0;
            gap_q   <= '0;
            beat_q  <= '0;
            cyc_q   <= '0;
            lfsr_q  <= SEED_EFF;
            en_q    <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= INIT_DATA;
            frame_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            gap_q   <= gap_d;
            beat_q  <= beat_d;
            cyc_q   <= cyc_d;
            lfsr_q  <= lfsr_d;
            en_q    <= en_d;
            last_q  <= last_d;
            data_q  <= data_d;
            frame_q <= frame_d;
            done_q  <= done_d;
        end
    end

    assign strm.data_en   = en_q;
    assign strm.data_last = last_q;
    assign strm.data_out  = data_q;
    assign frame_cnt      = frame_q;
    assign done           = done_q;

endmodule

// File: tb/tb_gearbox_stream_gen.sv
// Directed bench for gearbox_stream_gen: five configurations, each exercised by its own scenario task.
`timescale 1ns/1ps
module tb_gearbox_stream_gen;

    logic clk = 1'b0;
    always #2.5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic rst0, rst1, rst2, rst3, rst4;
    logic gen0, gen1, gen2, gen3, gen4;
    logic [31:0] fc0, fc1, fc2, fc3, fc4;
    logic dn0, dn1, dn2, dn3, dn4;

    gearbox_stream_gen_if #(.DATA_W(24)) if0 ();
    gearbox_stream_gen_if #(.DATA_W(24)) if1 ();
    gearbox_stream_gen_if #(.DATA_W(24)) if2 ();
    gearbox_stream_gen_if #(.DATA_W(24)) if3 ();
    gearbox_stream_gen_if #(.DATA_W(24)) if4 ();

    gearbox_stream_gen u0 (
        .clk_200m(clk), .reset_n(rst0), .gen_en(gen0), .strm(if0), .frame_cnt(fc0), .done(dn0));

    gearbox_stream_gen #(.MODE(1), .FRAME_LEN(8), .START_DLY(4)) u1 (
        .clk_200m(clk), .reset_n(rst1), .gen_en(gen1), .strm(if1), .frame_cnt(fc1), .done(dn1));

    gearbox_stream_gen #(.FRAME_LEN(16), .NUM_FRAMES(2), .START_DLY(3)) u2 (
        .clk_200m(clk), .reset_n(rst2), .gen_en(gen2), .strm(if2), .frame_cnt(fc2), .done(dn2));

    gearbox_stream_gen #(.FRAME_LEN(4), .GAP_LEN(5), .NUM_FRAMES(3), .START_DLY(2)) u3 (
        .clk_200m(clk), .reset_n(rst3), .gen_en(gen3), .strm(if3), .frame_cnt(fc3), .done(dn3));

    gearbox_stream_gen #(.INIT_DATA(24'hFF_FE_FD), .FRAME_LEN(4), .NUM_FRAMES(2), .START_DLY(2)) u4 (
        .clk_200m(clk), .reset_n(rst4), .gen_en(gen4), .strm(if4), .frame_cnt(fc4), .done(dn4));

    function automatic logic [23:0] inc3(input logic [23:0] d);
        return {d[23:16] + 8'd1, d[15:8] + 8'd1, d[7:0] + 8'd1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        total_cnt++; if (if0.data_en !== 1'b0) $display("FAIL rst_en got=%b exp=0", if0.data_en); else pass_cnt++;
        total_cnt++; if (if0.data_last !== 1'b0) $display("FAIL rst_last got=%b exp=0", if0.data_last); else pass_cnt++;
        total_cnt++; if (if0.data_out !== 24'h302010) $display("FAIL rst_data got=%h exp=302010", if0.data_out); else pass_cnt++;
        total_cnt++; if (fc0 !== 32'd0) $display("FAIL rst_fcnt got=%0d exp=0", fc0); else pass_cnt++;
        total_cnt++; if (dn0 !== 1'b0) $display("FAIL rst_done got=%b exp=0", dn0); else pass_cnt++;
        total_cnt++; if (if4.data_out !== 24'hFFFEFD) $display("FAIL rst_data_u4 got=%h exp=fffefd", if4.data_out); else pass_cnt++;
    endtask

    task automatic test_default_frame();
        int n, first_en, beats, bad, post_en;
        logic [23:0] exp_d, last_d;
        gen0 = 1'b1; if0.data_rdy = 1'b1; rst0 = 1'b1;
        n = 0; first_en = -1; beats = 0; bad = 0; exp_d = 24'h302010; last_d = '0;
        while (!dn0 && n < 12000) begin
            tick(); n++;
            if (if0.data_en && first_en < 0) first_en = n;
            if (if0.data_en && if0.data_rdy) begin
                if (if0.data_out !== exp_d) bad++;
                if (if0.data_last !== (beats == 9009)) bad++;
                if (if0.data_last) last_d = if0.data_out;
                exp_d = inc3(exp_d);
                beats++;
            end
        end
        total_cnt++; if (first_en < 1000 || first_en > 1002) $display("FAIL def_first_beat got=%0d exp=1001", first_en); else pass_cnt++;
        total_cnt++; if (bad != 0) $display("FAIL def_sequence got=%0d errors exp=0", bad); else pass_cnt++;
        total_cnt++; if (beats != 9010) $display("FAIL def_beats got=%0d exp=9010", beats); else pass_cnt++;
        total_cnt++; if (last_d !== 24'h615141) $display("FAIL def_last_data got=%h exp=615141", last_d); else pass_cnt++;
        total_cnt++; if (dn0 !== 1'b1) $display("FAIL def_done got=%b exp=1", dn0); else pass_cnt++;
        total_cnt++; if (fc0 !== 32'd1) $display("FAIL def_fcnt got=%0d exp=1", fc0); else pass_cnt++;
        post_en = 0;
        repeat (10) begin tick(); if (if0.data_en) post_en++; end
        total_cnt++; if (post_en != 0 || dn0 !== 1'b1) $display("FAIL def_done_hold en_cycles=%0d done=%b exp 0/1", post_en, dn0); else pass_cnt++;
    endtask

    task automatic test_mode1_burst();
        logic [31:0] o_en, o_last, o_dn;
        logic [23:0] exp_d;
        int bad, beats;
        gen1 = 1'b1; if1.data_rdy = 1'b1; rst1 = 1'b1;
        o_en = '0; o_last = '0; o_dn = '0; exp_d = 24'h302010; bad = 0; beats = 0;
        for (int n = 1; n <= 24; n++) begin
            tick();
            o_en[n] = if1.data_en; o_last[n] = if1.data_last; o_dn[n] = dn1;
            if (if1.data_en && if1.data_rdy) begin
                if (if1.data_out !== exp_d) bad++;
                exp_d = inc3(exp_d);
                beats++;
            end
        end
        total_cnt++; if (o_en !== 32'h0019_9980) $display("FAIL m1_en_pattern got=%h exp=00199980", o_en); else pass_cnt++;
        total_cnt++; if (o_last !== 32'h0010_0000) $display("FAIL m1_last_pattern got=%h exp=00100000", o_last); else pass_cnt++;
        total_cnt++; if (bad != 0 || beats != 8) $display("FAIL m1_data errors=%0d beats=%0d exp 0/8", bad, beats); else pass_cnt++;
        total_cnt++; if (o_dn[20] !== 1'b0 || o_dn[21] !== 1'b1) $display("FAIL m1_done got=%b%b exp=01", o_dn[20], o_dn[21]); else pass_cnt++;
    endtask

    task automatic test_rdy_stall();
        int n, beats, hold_bad, seq_bad;
        logic [23:0] exp_d, pd;
        logic pl, pend;
        gen2 = 1'b1; if2.data_rdy = 1'b0; rst2 = 1'b1;
        n = 0; beats = 0; hold_bad = 0; seq_bad = 0; exp_d = 24'h302010; pend = 1'b0; pd = '0; pl = 1'b0;
        while (!dn2 && n < 600) begin
            tick(); n++;
            if (pend && (if2.data_en !== 1'b1 || if2.data_out !== pd || if2.data_last !== pl)) hold_bad++;
            if2.data_rdy = 1'($urandom_range(0, 1));
            if (if2.data_en && if2.data_rdy) begin
                if (if2.data_out !== exp_d) seq_bad++;
                if (if2.data_last !== ((beats % 16) == 15)) seq_bad++;
                exp_d = inc3(exp_d);
                beats++;
            end
            pend = if2.data_en && !if2.data_rdy;
            pd = if2.data_out; pl = if2.data_last;
        end
        if2.data_rdy = 1'b1;
        total_cnt++; if (hold_bad != 0) $display("FAIL stall_hold got=%0d errors exp=0", hold_bad); else pass_cnt++;
        total_cnt++; if (seq_bad != 0) $display("FAIL stall_sequence got=%0d errors exp=0", seq_bad); else pass_cnt++;
        total_cnt++; if (beats != 32) $display("FAIL stall_beats got=%0d exp=32", beats); else pass_cnt++;
        total_cnt++; if (fc2 !== 32'd2 || dn2 !== 1'b1) $display("FAIL stall_end fcnt=%0d done=%b exp 2/1", fc2, dn2); else pass_cnt++;
    endtask

    task automatic test_gap_frames();
        logic [31:0] o_en, o_last, o_dn;
        logic [31:0] fc_at [32];
        logic [23:0] exp_d;
        int bad, beats;
        gen3 = 1'b1; if3.data_rdy = 1'b1; rst3 = 1'b1;
        o_en = '0; o_last = '0; o_dn = '0; exp_d = 24'h302010; bad = 0; beats = 0;
        for (int n = 0; n < 32; n++) fc_at[n] = '0;
        for (int n = 1; n <= 30; n++) begin
            tick();
            o_en[n] = if3.data_en; o_last[n] = if3.data_last; o_dn[n] = dn3; fc_at[n] = fc3;
            if (if3.data_en && if3.data_rdy) begin
                if (if3.data_out !== exp_d) bad++;
                exp_d = inc3(exp_d);
                beats++;
            end
        end
        total_cnt++; if (o_en !== 32'h01E0_F078) $display("FAIL gap_en_pattern got=%h exp=01e0f078", o_en); else pass_cnt++;
        total_cnt++; if (o_last !== 32'h0100_8040) $display("FAIL gap_last_pattern got=%h exp=01008040", o_last); else pass_cnt++;
        total_cnt++; if (fc_at[6] !== 32'd0 || fc_at[7] !== 32'd1) $display("FAIL gap_fcnt1 got=%0d,%0d exp=0,1", fc_at[6], fc_at[7]); else pass_cnt++;
        total_cnt++; if (fc_at[15] !== 32'd1 || fc_at[16] !== 32'd2) $display("FAIL gap_fcnt2 got=%0d,%0d exp=1,2", fc_at[15], fc_at[16]); else pass_cnt++;
        total_cnt++; if (fc_at[25] !== 32'd3) $display("FAIL gap_fcnt3 got=%0d exp=3", fc_at[25]); else pass_cnt++;
        total_cnt++; if (o_dn[24] !== 1'b0 || o_dn[25] !== 1'b1) $display("FAIL gap_done got=%b%b exp=01", o_dn[24], o_dn[25]); else pass_cnt++;
        total_cnt++; if (bad != 0 || beats != 12) $display("FAIL gap_data errors=%0d beats=%0d exp 0/12", bad, beats); else pass_cnt++;
    endtask

    task automatic test_reset_async();
        int first_en;
        rst3 = 1'b0; tick();
        gen3 = 1'b1; if3.data_rdy = 1'b1; rst3 = 1'b1;
        repeat (13) tick();
        total_cnt++; if (if3.data_en !== 1'b1 || fc3 !== 32'd1) $display("FAIL arst_pre en=%b fcnt=%0d exp 1/1", if3.data_en, fc3); else pass_cnt++;
        #1 rst3 = 1'b0;
        #1;
        total_cnt++; if (if3.data_en !== 1'b0 || if3.data_last !== 1'b0) $display("FAIL arst_ctrl en=%b last=%b exp 0/0", if3.data_en, if3.data_last); else pass_cnt++;
        total_cnt++; if (if3.data_out !== 24'h302010) $display("FAIL arst_data got=%h exp=302010", if3.data_out); else pass_cnt++;
        total_cnt++; if (fc3 !== 32'd0 || dn3 !== 1'b0) $display("FAIL arst_cnt fcnt=%0d done=%b exp 0/0", fc3, dn3); else pass_cnt++;
        repeat (3) tick();
        rst3 = 1'b1;
        first_en = -1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (if3.data_en && first_en < 0) first_en = n;
        end
        total_cnt++; if (first_en != 3) $display("FAIL arst_restart got=%0d exp=3", first_en); else pass_cnt++;
    endtask

    task automatic test_lane_wrap();
        logic [23:0] exp4 [8];
        logic [31:0] o_en, o_last, o_dn;
        logic [31:0] fc_at [32];
        int bad, beats;
        exp4[0] = 24'hFFFEFD; exp4[1] = 24'h00FFFE; exp4[2] = 24'h0100FF; exp4[3] = 24'h020100;
        exp4[4] = 24'h030201; exp4[5] = 24'h040302; exp4[6] = 24'h050403; exp4[7] = 24'h060504;
        gen4 = 1'b1; if4.data_rdy = 1'b1; rst4 = 1'b1;
        o_en = '0; o_last = '0; o_dn = '0; bad = 0; beats = 0;
        for (int n = 0; n < 32; n++) fc_at[n] = '0;
        for (int n = 1; n <= 30; n++) begin
            tick();
            o_en[n] = if4.data_en; o_last[n] = if4.data_last; o_dn[n] = dn4; fc_at[n] = fc4;
            if (if4.data_en && if4.data_rdy) begin
                if (beats > 7 || if4.data_out !== exp4[beats[2:0]]) bad++;
                beats++;
            end
            if (n == 4) gen4 = 1'b0;
            if (n == 12) gen4 = 1'b1;
        end
        total_cnt++; if (bad != 0 || beats != 8) $display("FAIL wrap_data errors=%0d beats=%0d exp 0/8", bad, beats); else pass_cnt++;
        total_cnt++; if (o_en !== 32'h0007_8078) $display("FAIL wrap_en_pattern got=%h exp=00078078", o_en); else pass_cnt++;
        total_cnt++; if (o_last !== 32'h0004_0040) $display("FAIL wrap_last_pattern got=%h exp=00040040", o_last); else pass_cnt++;
        total_cnt++; if (fc_at[12] !== 32'd1 || o_dn[12] !== 1'b0) $display("FAIL wrap_idle fcnt=%0d done=%b exp 1/0", fc_at[12], o_dn[12]); else pass_cnt++;
        total_cnt++; if (fc_at[19] !== 32'd2 || o_dn[18] !== 1'b0 || o_dn[19] !== 1'b1) $display("FAIL wrap_done fcnt=%0d done=%b%b exp 2/01", fc_at[19], o_dn[18], o_dn[19]); else pass_cnt++;
    endtask

    initial begin
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0; rst4 = 1'b0;
        gen0 = 1'b0; gen1 = 1'b0; gen2 = 1'b0; gen3 = 1'b0; gen4 = 1'b0;
        if0.data_rdy = 1'b1; if1.data_rdy = 1'b1; if2.data_rdy = 1'b1;
        if3.data_rdy = 1'b1; if4.data_rdy = 1'b1;
        repeat (3) tick();
        test_reset();
        test_default_frame();
        test_mode1_burst();
        test_rdy_stall();
        test_gap_frames();
        test_reset_async();
        test_lane_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog expired passed=%0d total=%0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

endmodule
